fcvt_s_wu_iter: RTL and testbench

FCVT_S_WU_ITER -- requirements
Module: fcvt_s_wu_iter

---
 rtl/fcvt_s_wu_iter_if.sv | 26 ++
 rtl/fcvt_s_wu_iter.sv | 142 ++++++++++++++
 tb/tb_fcvt_s_wu_iter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fcvt_s_wu_iter_if.sv
// Handshake bundle for the iterative integer-to-float converter.
// The master drives the operand and consumes the result; the slave is the converter.
interface fcvt_s_wu_iter_if #(
    parameter int F_WIDTH = 32,
    parameter int I_WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [I_WIDTH-1:0] in1;
    logic               is_signed;
    logic [2:0]         rm;
    logic               out_valid;
    logic               out_ready;
    logic [F_WIDTH-1:0] out1;
    logic               inexact;

    modport master (
        output in_valid, in1, is_signed, rm, out_ready,
        input  in_ready, out_valid, out1, inexact
    );

    modport slave (
        input  in_valid, in1, is_signed, rm, out_ready,
        output in_ready, out_valid, out1, inexact
    );
endinterface

// File: rtl/fcvt_s_wu_iter.sv
// Iterative FCVT.S.W / FCVT.S.WU: normalises the magnitude one bit per cycle,
// then rounds once according to rm and holds the result until the consumer takes it.
module fcvt_s_wu_iter #(
    parameter int F_WIDTH = 32,
    parameter int F_EXP   = 8,
    parameter int F_FLAC  = 23,
    parameter int I_WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    fcvt_s_wu_iter_if.slave  io
);

    localparam int BIAS    = 2 ** (F_EXP - 1) - 1;
    localparam int MSB     = I_WIDTH - 1;
    localparam int G_POS   = I_WIDTH - 2 - F_FLAC;
    localparam logic [F_EXP-1:0] EXP_INIT = F_EXP'(BIAS + I_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [I_WIDTH-1:0] mag_q, mag_d;
    logic [F_EXP-1:0]   exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [2:0]         rm_q, rm_d;
    logic [F_WIDTH-1:0] out1_q, out1_d;
    logic               inexact_q, inexact_d;

    logic               in_sign;
    logic [I_WIDTH-1:0] in_mag;
    logic [F_FLAC-1:0]  mant;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic [F_FLAC:0]    mant_sum;
    logic               carry;
    logic [F_EXP-1:0]   exp_rnd;
    logic [F_FLAC-1:0]  mant_rnd;

    // Operand decode: only the two's-complement form with the sign bit set is negated.
    always_comb begin
        in_sign = io.is_signed & io.in1[MSB];
        in_mag  = in_sign ? (~io.in1 + I_WIDTH'(1)) : io.in1;
    end

    // Rounding datapath, valid once mag has its leading one at the MSB.
    always_comb begin
        mant   = mag_q[MSB-1 -: F_FLAC];
        guard  = mag_q[G_POS];
        sticky = |mag_q[G_POS-1:0];
        case (rm_q)
            3'b001:  round_up = 1'b0;
            3'b010:  round_up = sign_q & (guard | sticky);
            3'b011:  round_up = ~sign_q & (guard | sticky);
            3'b100:  round_up = guard;
            default: round_up = guard & (sticky | mant[0]);
        endcase
        mant_sum = {1'b0, mant} + (F_FLAC + 1)'(round_up);
        carry    = mant_sum[F_FLAC];
        exp_rnd  = exp_q + F_EXP'(carry);
        mant_rnd = carry ? '0 : mant_sum[F_FLAC-1:0];
    end

    // Next-state logic; every register holds unless its state says otherwise.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        rm_d      = rm_q;
        out1_d    = out1_q;
        inexact_d = inexact_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    sign_d = in_sign;
                    mag_d  = in_mag;
                    rm_d   = io.rm;
                    exp_d  = EXP_INIT;
                    if (in_mag == '0) begin
                        out1_d    = '0;
                        inexact_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[MSB]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - F_EXP'(1);
                end
            end
            ROUND: begin
                out1_d    = {sign_q, exp_rnd, mant_rnd};
                inexact_d = guard | sticky;
                state_d   = DONE;
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            rm_q      <= '0;
            out1_q    <= '0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            rm_q      <= rm_d;
            out1_q    <= out1_d;
            inexact_q <= inexact_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.out1      = out1_q;
    assign io.inexact   = inexact_q;

endmodule

// File: tb/tb_fcvt_s_wu_iter.sv
// Scoreboard bench for fcvt_s_wu_iter: stimulus pushes model results into a queue,
// a negedge monitor compares result, flag and latency whenever out_valid is up.
module tb_fcvt_s_wu_iter;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    always #5 CLK = ~CLK;

    fcvt_s_wu_iter_if #(.F_WIDTH(32), .I_WIDTH(32)) io ();

    fcvt_s_wu_iter #(
        .F_WIDTH(32),
        .F_EXP  (8),
        .F_FLAC (23),
        .I_WIDTH(32)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .io  (io)
    );

    typedef struct {
        logic [31:0] out1;
        logic        inexact;
        int          lat;
    } expect_t;

    expect_t sb[$];
    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int accept_cyc = 0;
    int first_cyc  = 0;
    bit seen       = 1'b0;

    // Reference conversion from the real value: truncate, compare the remainder with half an ulp.
    function automatic expect_t refModel(logic [31:0] a, bit s, logic [2:0] rm);
        expect_t r;
        bit sign = s && a[31];
        longint unsigned mag = sign ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        longint unsigned q, rem, half;
        int e, e_in, shift;
        bit up;
        if (mag == 0) begin
            r.out1 = 32'h0; r.inexact = 1'b0; r.lat = 1;
            return r;
        end
        e = 0;
        for (int i = 0; i < 32; i++) if (((mag >> i) & 1) != 0) e = i;
        e_in = e;
        if (e <= 23) begin
            q = mag << (23 - e); rem = 0; half = 1;
        end else begin
            shift = e - 23;
            q     = mag >> shift;
            rem   = mag & ((64'd1 << shift) - 1);
            half  = 64'd1 << (shift - 1);
        end
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = sign && (rem != 0);
            3'd3:    up = !sign && (rem != 0);
            3'd4:    up = (rem != 0) && (rem >= half);
            default: up = (rem > half) || ((rem == half) && (rem != 0) && (q % 2 == 1));
        endcase
        q = q + (up ? 1 : 0);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        r.out1    = {sign, 8'(e + 127), 23'(q)};
        r.inexact = (rem != 0);
        r.lat     = (31 - e_in) + 3;
        return r;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic waitCycle();
        @(posedge CLK);
        #1;
    endtask

    // Issue one operand, then keep out_ready low for 'hold' cycles once the result shows up.
    task automatic applyStimulus(logic [31:0] a, bit s, logic [2:0] rm, int hold);
        int guard_cnt = 0;
        while (!io.in_ready && guard_cnt < 100) begin
            waitCycle();
            guard_cnt++;
        end
        if (!io.in_ready) begin
            checkOutput("accept_timeout", {31'h0, io.in_ready}, 32'h1);
            return;
        end
        io.in1       = a;
        io.is_signed = s;
        io.rm        = rm;
        io.in_valid  = 1'b1;
        io.out_ready = 1'b0;
        sb.push_back(refModel(a, s, rm));
        waitCycle();
        io.in_valid  = 1'b0;
        io.in1       = $urandom;
        io.is_signed = 1'($urandom);
        io.rm        = 3'($urandom);
        guard_cnt    = 0;
        while (!io.out_valid && guard_cnt < 100) begin
            waitCycle();
            guard_cnt++;
        end
        if (!io.out_valid) begin
            checkOutput("result_timeout", {31'h0, io.out_valid}, 32'h1);
            sb.delete();
            seen = 1'b0;
            return;
        end
        repeat (hold) waitCycle();
        io.out_ready = 1'b1;
        waitCycle();
        io.out_ready = 1'b0;
    endtask

    always @(posedge CLK) begin
        if (RSTn && io.in_valid && io.in_ready) accept_cyc = cyc;
        cyc = cyc + 1;
    end

    // Monitor: result must match the queue head every cycle it is presented.
    always @(negedge CLK) begin
        if (RSTn && io.out_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", {31'h0, io.out_valid}, 32'h0);
            end else begin
                checkOutput("out1", io.out1, sb[0].out1);
                checkOutput("inexact", {31'h0, io.inexact}, {31'h0, sb[0].inexact});
                checkOutput("in_ready_in_done", {31'h0, io.in_ready}, 32'h0);
                if (io.out_ready) begin
                    checkOutput("latency", 32'(first_cyc - accept_cyc), 32'(sb[0].lat));
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        io.in_valid  = 1'b0;
        io.in1       = 32'h0;
        io.is_signed = 1'b0;
        io.rm        = 3'd0;
        io.out_ready = 1'b0;

        repeat (3) waitCycle();
        checkOutput("reset_out_valid", {31'h0, io.out_valid}, 32'h0);
        checkOutput("reset_out1", io.out1, 32'h0);
        checkOutput("reset_inexact", {31'h0, io.inexact}, 32'h0);
        RSTn = 1'b1;
        checkOutput("reset_in_ready", {31'h0, io.in_ready}, 32'h1);

        applyStimulus(32'h0000_0001, 1'b0, 3'd0, 0);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 3'd0, 1);
        applyStimulus(32'hFFFF_FFFF, 1'b0, 3'd1, 0);
        applyStimulus(32'hFFFF_FFFF, 1'b1, 3'd0, 0);
        applyStimulus(32'h8000_0000, 1'b1, 3'd0, 0);
        applyStimulus(32'h0100_0001, 1'b0, 3'd0, 0);
        applyStimulus(32'h0100_0001, 1'b0, 3'd3, 0);
        applyStimulus(32'h0100_0001, 1'b0, 3'd4, 0);
        applyStimulus(32'h0000_0000, 1'b1, 3'd0, 0);
        applyStimulus(32'h0000_0000, 1'b0, 3'd2, 0);
        applyStimulus(32'h8000_0001, 1'b1, 3'd2, 0);
        applyStimulus(32'h0123_4567, 1'b0, 3'd7, 5);

        // Abort an operation mid-normalisation; nothing may come out afterwards.
        while (!io.in_ready) waitCycle();
        io.in1       = 32'h0000_0003;
        io.is_signed = 1'b0;
        io.in_valid  = 1'b1;
        waitCycle();
        io.in_valid = 1'b0;
        repeat (3) waitCycle();
        RSTn = 1'b0;
        waitCycle();
        RSTn = 1'b1;
        sb.delete();
        seen = 1'b0;
        checkOutput("abort_out_valid", {31'h0, io.out_valid}, 32'h0);
        checkOutput("abort_in_ready", {31'h0, io.in_ready}, 32'h1);
        repeat (40) waitCycle();
        checkOutput("abort_no_result", {31'h0, io.out_valid}, 32'h0);

        for (int n = 0; n < 150; n++) begin
            a = $urandom >> $urandom_range(0, 31);
            applyStimulus(a, 1'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 2));
        end

        repeat (3) waitCycle();
        checkOutput("queue_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
